// File: rtl/fifo_n_guarded_if.sv
// fifo_n_guarded_if: enqueue/dequeue handshake bundle between producer/consumer rules and fifo_n_guarded
interface fifo_n_guarded_if #(parameter int width = 1, parameter int depth = 4);
  logic [width-1:0] D_IN;
  logic [width-1:0] D_OUT;
  logic ENQ;
  logic DEQ;
  logic CLR;
  logic FULL_N;
  logic FULL1_N;
  logic EMPTY_N;
  logic ALMOST_FULL_N;
  logic [$clog2(depth):0] COUNT;
  modport master (output D_IN, ENQ, DEQ, CLR, input D_OUT, FULL_N, FULL1_N, EMPTY_N, ALMOST_FULL_N, COUNT);
  modport slave (input D_IN, ENQ, DEQ, CLR, output D_OUT, FULL_N, FULL1_N, EMPTY_N, ALMOST_FULL_N, COUNT);
endinterface

// File: rtl/fifo_n_guarded.sv
// fifo_n_guarded: N-deep W-wide sync FIFO with count, almost-full and full-lookahead flags.
// Define FIFO_N_GUARDED_INIT_EN to clear storage on RST/CLR (D_OUT=0 after reset or flush).
module fifo_n_guarded #(
  parameter int width = 1,
  parameter int depth = 4,
  parameter int afull = depth - 1,
  parameter int guarded = 1
) (
  input logic CLK,
  input logic RST,
  fifo_n_guarded_if.slave f
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] n_c = (aw+1)'(depth);
  localparam logic [aw:0] nm1_c = (aw+1)'(depth - 1);
  localparam logic [aw:0] af_c = (aw+1)'(afull);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [aw:0] cnt;
  logic enq_ok, deq_ok, wr_en;
  assign enq_ok = f.ENQ && (cnt != n_c || f.DEQ);
  assign deq_ok = f.DEQ && cnt != '0;
  assign wr_en = enq_ok && !RST && !f.CLR;
  assign f.D_OUT = mem[rd_ptr];
  assign f.FULL_N = cnt != n_c;
  assign f.EMPTY_N = cnt != '0;
  assign f.COUNT = cnt;
  assign f.ALMOST_FULL_N = cnt < af_c;
  assign f.FULL1_N = !((cnt == n_c && !f.DEQ) || (cnt == nm1_c && f.ENQ && !f.DEQ));
  always_ff @(posedge CLK) begin
    if (RST || f.CLR) begin
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_ok) wr_ptr <= wr_ptr + 1'b1;
      if (deq_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{aw{1'b0}}, enq_ok} - {{aw{1'b0}}, deq_ok};
    end
  end
  always_ff @(posedge CLK) begin
`ifdef FIFO_N_GUARDED_INIT_EN
    if (RST || f.CLR) for (int i = 0; i < depth; i++) mem[i] <= '0;
    else
`endif
    if (wr_en) mem[wr_ptr] <= f.D_IN;
  end
  // simulation-only diagnostics; synthesis ignores the severity tasks
  always_ff @(posedge CLK) begin
    if (!RST && f.DEQ && cnt == '0) $warning("Dequeuing from empty fifo");
    if (!RST && guarded != 0 && f.ENQ && !f.DEQ && cnt == n_c) $warning("Enqueuing to a full fifo");
  end
endmodule

// File: tb/tb_fifo_n_guarded.sv
// tb_fifo_n_guarded: directed plus random stimulus checked every cycle against a queue model.
module tb_fifo_n_guarded;
  logic CLK = 0;
  logic RST = 1;
  always #5 CLK = ~CLK;
  fifo_n_guarded_if #(.width(8), .depth(4)) f ();
  fifo_n_guarded #(.width(8), .depth(4), .afull(3), .guarded(1)) dut (.CLK(CLK), .RST(RST), .f(f));
  byte unsigned q[$];
  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;
  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
  endtask
  task automatic drive(input bit e, input bit d, input bit c, input bit r, input logic [7:0] din);
    f.ENQ = e;
    f.DEQ = d;
    f.CLR = c;
    RST = r;
    f.D_IN = din;
  endtask
  // expected outputs come straight from the queue occupancy and current strobes
  task automatic compare;
    int s;
    s = q.size();
    chk("count", int'(f.COUNT), s);
    chk("full_n", int'(f.FULL_N), int'(s != 4));
    chk("empty_n", int'(f.EMPTY_N), int'(s != 0));
    chk("almost_full_n", int'(f.ALMOST_FULL_N), int'(s < 3));
    chk("full1_n", int'(f.FULL1_N), int'(!((s == 4 && !f.DEQ) || (s == 3 && f.ENQ && !f.DEQ))));
    if (s > 0) chk("d_out", int'(f.D_OUT), int'(q[0]));
  endtask
  task automatic tick;
    bit en_ok, de_ok;
    @(negedge CLK);
    if (chk_en) compare();
    @(posedge CLK);
    if (RST || f.CLR) q.delete();
    else begin
      en_ok = f.ENQ && (q.size() < 4 || f.DEQ);
      de_ok = f.DEQ && q.size() != 0;
      if (de_ok) void'(q.pop_front());
      if (en_ok) q.push_back(f.D_IN);
    end
    #1;
  endtask
  task automatic step(input bit e, input bit d, input bit c, input bit r, input logic [7:0] din);
    drive(e, d, c, r, din);
    tick();
  endtask
  initial begin
    drive(0, 0, 0, 1, 0);
    tick();
    tick();
    chk_en = 1;
    drive(0, 0, 0, 0, 0);
    chk("rst_count", int'(f.COUNT), 0);
    chk("rst_full_n", int'(f.FULL_N), 1);
    chk("rst_empty_n", int'(f.EMPTY_N), 0);
    chk("rst_full1_n", int'(f.FULL1_N), 1);
    chk("rst_afull_n", int'(f.ALMOST_FULL_N), 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 8'(8'h11 * (i + 1)));
      if (i == 3) begin
        #1;
        chk("full1_on_4th_enq", int'(f.FULL1_N), 0);
      end
      tick();
    end
    chk("fill_count", int'(f.COUNT), 4);
    chk("fill_full_n", int'(f.FULL_N), 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0);
      chk("drain_dout", int'(f.D_OUT), 8'h11 * (i + 1));
      tick();
    end
    chk("drain_empty_n", int'(f.EMPTY_N), 0);
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 8'(r * 3 + k));
      for (int k = 0; k < 3; k++) begin
        drive(0, 1, 0, 0, 0);
        chk("wrap_dout", int'(f.D_OUT), r * 3 + k);
        tick();
      end
      chk("wrap_count", int'(f.COUNT), 0);
    end
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, 8'(i));
    step(1, 1, 0, 0, 8'hAA);
    chk("simul_full_count", int'(f.COUNT), 4);
    chk("simul_full_head", int'(f.D_OUT), 2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("simul_aa_out", int'(f.D_OUT), 8'hAA);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 8'h77);
    chk("simul_empty_count", int'(f.COUNT), 1);
    chk("simul_empty_dout", int'(f.D_OUT), 8'h77);
    step(0, 1, 0, 0, 0);
    for (int i = 5; i <= 8; i++) step(1, 0, 0, 0, 8'(i));
    step(1, 0, 0, 0, 8'h55);
    chk("ovf_count", int'(f.COUNT), 4);
    for (int i = 5; i <= 8; i++) begin
      drive(0, 1, 0, 0, 0);
      chk("ovf_dout", int'(f.D_OUT), i);
      tick();
    end
    chk("ovf_empty_n", int'(f.EMPTY_N), 0);
    for (int i = 9; i <= 11; i++) step(1, 0, 0, 0, 8'(i));
    chk("afull_n_at3", int'(f.ALMOST_FULL_N), 0);
    step(1, 0, 1, 0, 8'h99);
    chk("clr_count", int'(f.COUNT), 0);
    chk("clr_empty_n", int'(f.EMPTY_N), 0);
    chk("clr_full_n", int'(f.FULL_N), 1);
    chk("clr_afull_n", int'(f.ALMOST_FULL_N), 1);
`ifdef FIFO_N_GUARDED_INIT_EN
    chk("clr_dout_zero", int'(f.D_OUT), 0);
`endif
    step(1, 0, 0, 0, 8'h21);
    step(1, 0, 0, 0, 8'h22);
    step(1, 1, 0, 1, 8'h33);
    chk("midrst_count", int'(f.COUNT), 0);
    chk("midrst_empty_n", int'(f.EMPTY_N), 0);
    chk("midrst_full_n", int'(f.FULL_N), 1);
    chk("midrst_afull_n", int'(f.ALMOST_FULL_N), 1);
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 40) == 0,
           $urandom_range(0, 80) == 0, 8'($urandom));
    step(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
